wasm_compare_unit: RTL and testbench
====================================

WASM_COMPARE_UNIT -- requirements
Module: wasm_compare_unit

Interface
REQ-001 Parameter STAGES, default 2: compare-pipeline latency in cycles; legal range 1..4.
REQ-002 Parameter FIFO_DEPTH, default 4: result-FIFO entries; power of two, at least 2.
REQ-003 clk  input  1  single clock for all state; every flop is rising-edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-005 in_valid  input  1  an operation is offered this cycle.
REQ-006 in_ready  output  1  the unit accepts the offered operation at this edge.
REQ-007 opcode  input  8  WebAssembly comparison opcode, 0x45..0x5A.
REQ-008 lhs  input  64  first-popped operand (c1); i32 operations use bits [31:0] only.
REQ-009 rhs  input  64  second operand (c2); ignored for eqz operations.
REQ-010 result  output  64  FIFO head, zero-extended 0 or 1; 0 when the FIFO is empty.
REQ-011 result_empty  output  1  high when the FIFO holds no entry.
REQ-012 result_pop  input  1  removes the head entry at the edge.
REQ-013 trap  output  3  0 = none; 3'd2 = invalid opcode; sticky until reset.

Function
REQ-014 Handshake: an operation is accepted at an edge where in_valid and in_ready are both high; nothing is accepted otherwise.
REQ-015 Credit rule: in_ready = (trap == 0) and (FIFO occupancy + in-flight operations + 1 <= FIFO_DEPTH + pop-this-cycle); this rule never drops a result.
REQ-016 Latency: for an operation accepted at edge N, its result reaches the FIFO at edge N+STAGES.
REQ-017 Throughput: the unit accepts one operation per cycle while credit allows.
REQ-018 Results leave the FIFO in acceptance order.
REQ-019 Operation encoding, result 1 when true and 0 otherwise:
- i32 ops on bits [31:0]: 0x45 eqz, 0x46 eq, 0x47 ne, 0x48 lt_s, 0x49 lt_u, 0x4A gt_s, 0x4B gt_u, 0x4C le_s, 0x4D le_u, 0x4E ge_s, 0x4F ge_u.
- i64 ops on all 64 bits: 0x50..0x5A, in the same order.
REQ-020 Signed compares use two's complement at the operation width; for i32 ops, upper operand bits never affect the result.
REQ-021 Invalid opcode:
- An accepted opcode outside 0x45..0x5A produces no FIFO entry.
- trap becomes 3'd2 at that acceptance edge.
- in_ready stays low until reset.
REQ-022 Operations already in flight when a trap occurs still complete and reach the FIFO.
REQ-023 FIFO pointers wrap modulo FIFO_DEPTH; occupancy ranges 0..FIFO_DEPTH.
REQ-024 result_pop while result_empty is high is ignored; occupancy does not underflow.
REQ-025 A push and a pop at the same edge leave occupancy unchanged.
REQ-026 A push into an empty FIFO is visible at the head (result_empty low) after that same edge.

Reset
REQ-027 While reset is high: in_ready=0, result=0, result_empty=1, trap=0.
REQ-028 Reset clears the FIFO, all pipeline valid bits and credit counters.
REQ-029 Reset asserted mid-operation discards in-flight results; none appear after reset releases.
REQ-030 in_ready rises in the first cycle after reset deasserts.

Verification
REQ-031 Basic eq, STAGES=2: i32.eq (0x46), lhs=5, rhs=5, accepted at edge N -> result_empty falls after edge N+2, result=1; pop -> result_empty=1, result=0.
REQ-032 Signedness, back-to-back: 0x48 lhs=0xFFFFFFFF rhs=1 -> 1; 0x49 same operands -> 0; 0x53 lhs=0x00000000_FFFFFFFF rhs=1 -> 0; results appear on consecutive cycles in that order.
REQ-033 Masking and eqz: 0x46 lhs=0x1_00000007 rhs=0x7 -> 1; 0x45 lhs=0xABCD_00000000 -> 1; 0x50 with the same lhs -> 0.
REQ-034 Backpressure, FIFO_DEPTH=4: stream 6 operations with result_pop held low -> in_ready falls after 4 acceptances and exactly 4 entries are held; then pop every cycle -> remaining 2 accepted, 6 results in order, none lost or duplicated.
REQ-035 Trap: 0x46 accepted, then opcode 0x60 accepted -> trap=3'd2 and in_ready=0 from the next cycle; the eq result still appears; reset -> trap=0, result_empty=1.
REQ-036 Reset mid-flight: accept 2 operations, assert reset one cycle later -> result_empty stays 1 after release, with no stale results.

Source files
------------

// File: rtl/wasm_compare_unit.sv
// rtl/wasm_compare_unit.sv - WebAssembly i32/i64 compare unit: pipelined evaluation, credit-guarded result FIFO.
// Results are single bits zero-extended to 64; an illegal opcode latches trap code 2 until reset.

module wasm_cmp_eval (
  input  logic [7:0]  opcode,
  input  logic [63:0] lhs,
  input  logic [63:0] rhs,
  output logic        legal,
  output logic        res
);

  logic is_i64;
  logic eq32, lts32, ltu32, eqz32;
  logic eq64, lts64, ltu64, eqz64;
  logic eq, lts, ltu, eqz;

  assign legal  = (opcode >= 8'h45) && (opcode <= 8'h5A);
  assign is_i64 = (opcode >= 8'h50);

  assign eq32  = (lhs[31:0] == rhs[31:0]);
  assign lts32 = ($signed(lhs[31:0]) < $signed(rhs[31:0]));
  assign ltu32 = (lhs[31:0] < rhs[31:0]);
  assign eqz32 = (lhs[31:0] == 32'd0);

  assign eq64  = (lhs == rhs);
  assign lts64 = ($signed(lhs) < $signed(rhs));
  assign ltu64 = (lhs < rhs);
  assign eqz64 = (lhs == 64'd0);

  assign eq  = is_i64 ? eq64  : eq32;
  assign lts = is_i64 ? lts64 : lts32;
  assign ltu = is_i64 ? ltu64 : ltu32;
  assign eqz = is_i64 ? eqz64 : eqz32;

  // Every relation is derived from eq plus the two less-than flags.
  always_comb begin
    res = 1'b0;
    case (opcode)
      8'h45, 8'h50: res = eqz;
      8'h46, 8'h51: res = eq;
      8'h47, 8'h52: res = !eq;
      8'h48, 8'h53: res = lts;
      8'h49, 8'h54: res = ltu;
      8'h4A, 8'h55: res = !lts && !eq;
      8'h4B, 8'h56: res = !ltu && !eq;
      8'h4C, 8'h57: res = lts || eq;
      8'h4D, 8'h58: res = ltu || eq;
      8'h4E, 8'h59: res = !lts;
      8'h4F, 8'h5A: res = !ltu;
      default:      res = 1'b0;
    endcase
  end

endmodule

module wasm_cmp_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     push_data,
  input  logic                     pop,
  output logic                     head,
  output logic                     empty,
  output logic                     pop_fire,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign empty    = (count == '0);
  assign pop_fire = pop && !empty;
  assign head     = mem[rd_ptr] && !empty;

  // Upstream credit guarantees push never arrives while full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop_fire) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop_fire})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

module wasm_compare_unit #(
  parameter int STAGES     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  opcode,
  input  logic [63:0] lhs,
  input  logic [63:0] rhs,
  output logic [63:0] result,
  output logic        result_empty,
  input  logic        result_pop,
  output logic [2:0]  trap
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [2:0] TRAP_NONE   = 3'd0;
  localparam logic [2:0] TRAP_BAD_OP = 3'd2;

  logic [STAGES-1:0] pipe_vld;
  logic [STAGES-1:0] pipe_res;
  logic              op_legal;
  logic              cmp_res;
  logic              accept;
  logic              push;
  logic              pop_fire;
  logic              fifo_head;
  logic              fifo_empty;
  logic [AW:0]       occ;
  logic [3:0]        inflight;
  logic [7:0]        credit_need;
  logic [7:0]        credit_avail;

  wasm_cmp_eval u_eval (
    .opcode (opcode),
    .lhs    (lhs),
    .rhs    (rhs),
    .legal  (op_legal),
    .res    (cmp_res)
  );

  always_comb begin
    inflight = '0;
    for (int i = 0; i < STAGES; i++) begin
      inflight = inflight + {3'b000, pipe_vld[i]};
    end
  end

  // Reserve a FIFO slot for every operation still in the pipe so nothing is dropped.
  assign credit_need  = 8'(occ) + 8'(inflight) + 8'd1;
  assign credit_avail = 8'(FIFO_DEPTH) + {7'd0, pop_fire};
  assign in_ready     = !reset && (trap == TRAP_NONE) && (credit_need <= credit_avail);
  assign accept       = in_valid && in_ready;
  assign push         = pipe_vld[STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_vld <= '0;
      pipe_res <= '0;
      trap     <= TRAP_NONE;
    end else begin
      pipe_vld[0] <= accept && op_legal;
      pipe_res[0] <= cmp_res;
      for (int i = 1; i < STAGES; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_res[i] <= pipe_res[i-1];
      end
      if (accept && !op_legal) begin
        trap <= TRAP_BAD_OP;
      end
    end
  end

  wasm_cmp_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (pipe_res[STAGES-1]),
    .pop       (result_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .pop_fire  (pop_fire),
    .count     (occ)
  );

  assign result_empty = fifo_empty;
  assign result       = {63'd0, fifo_head};

endmodule

// File: tb/tb_wasm_compare_unit.sv
// tb/tb_wasm_compare_unit.sv - self-checking bench for wasm_compare_unit against a queue-based reference model.
module tb_wasm_compare_unit;

  localparam int STAGES = 2;
  localparam int DEPTH  = 4;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  opcode;
  logic [63:0] lhs;
  logic [63:0] rhs;
  logic [63:0] result;
  logic        result_empty;
  logic        result_pop;
  logic [2:0]  trap;

  wasm_compare_unit #(.STAGES(STAGES), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opcode       (opcode),
    .lhs          (lhs),
    .rhs          (rhs),
    .result       (result),
    .result_empty (result_empty),
    .result_pop   (result_pop),
    .trap         (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit val;
    int due;
  } pend_t;

  bit    fifo_q[$];
  pend_t pend_q[$];
  bit    m_trap;
  int    cyc;
  int    n_checks;
  int    n_errors;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_legal(input logic [7:0] op);
    return (op >= 8'h45) && (op <= 8'h5A);
  endfunction

  function automatic bit ref_cmp(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              s32a, s32b, k;
    if (op >= 8'h50) begin
      ua = a; ub = b; sa = a; sb = b;
      k = int'(op) - 'h50;
    end else begin
      ua = {32'd0, a[31:0]}; ub = {32'd0, b[31:0]};
      s32a = a[31:0]; s32b = b[31:0];
      sa = s32a; sb = s32b;
      k = int'(op) - 'h45;
    end
    case (k)
      0:       return ua == 0;
      1:       return ua == ub;
      2:       return ua != ub;
      3:       return sa < sb;
      4:       return ua < ub;
      5:       return sa > sb;
      6:       return ua > ub;
      7:       return sa <= sb;
      8:       return ua <= ub;
      9:       return sa >= sb;
      default: return ua >= ub;
    endcase
  endfunction

  function automatic logic [63:0] rnd_val();
    case ($urandom_range(0, 3))
      0:       return {$urandom, $urandom};
      1:       return 64'($urandom_range(0, 3));
      2:       return {32'($urandom), 32'h8000_0000 | 32'($urandom_range(0, 2))};
      default: return {32'($urandom_range(0, 1)), 32'hFFFF_FFFF};
    endcase
  endfunction

  // One clock: drive at negedge, check in_ready before the edge, update model, check outputs at next negedge.
  task automatic do_cycle(input string tag, input bit v, input logic [7:0] op,
                          input logic [63:0] a, input logic [63:0] b, input bit pop, output bit acc);
    bit exp_rdy;
    bit pop_m;
    logic [63:0] exp_res;
    in_valid = v; opcode = op; lhs = a; rhs = b; result_pop = pop;
    #1;
    pop_m   = pop && (fifo_q.size() > 0);
    exp_rdy = !m_trap && (fifo_q.size() + pend_q.size() + 1 <= DEPTH + int'(pop_m));
    check({tag, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
    acc = v && in_ready;
    @(posedge clk);
    cyc++;
    if (pop_m) void'(fifo_q.pop_front());
    while (pend_q.size() > 0 && pend_q[0].due == cyc) begin
      fifo_q.push_back(pend_q[0].val);
      void'(pend_q.pop_front());
    end
    if (acc) begin
      if (is_legal(op)) pend_q.push_back('{ref_cmp(op, a, b), cyc + STAGES});
      else m_trap = 1'b1;
    end
    @(negedge clk);
    exp_res = (fifo_q.size() == 0) ? 64'd0 : 64'(fifo_q[0]);
    check({tag, ".result_empty"}, 64'(result_empty), 64'(fifo_q.size() == 0));
    check({tag, ".result"}, result, exp_res);
    check({tag, ".trap"}, 64'(trap), m_trap ? 64'd2 : 64'd0);
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b1; in_valid = 1'b0; result_pop = 1'b0;
    #1;
    check({tag, ".rst_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, ".rst_result"}, result, 64'd0);
    check({tag, ".rst_empty"}, 64'(result_empty), 64'd1);
    check({tag, ".rst_trap"}, 64'(trap), 64'd0);
    repeat (2) @(negedge clk);
    check({tag, ".rst_hold_empty"}, 64'(result_empty), 64'd1);
    reset = 1'b0;
    fifo_q.delete();
    pend_q.delete();
    m_trap = 1'b0;
  endtask

  task automatic idle(input string tag, input int n, input bit pop);
    bit acc;
    for (int i = 0; i < n; i++) do_cycle(tag, 1'b0, 8'h46, 64'd0, 64'd0, pop, acc);
  endtask

  task automatic drain(input string tag);
    bit acc;
    for (int i = 0; i < 30 && (fifo_q.size() + pend_q.size()) > 0; i++)
      do_cycle(tag, 1'b0, 8'h46, 64'd0, 64'd0, 1'b1, acc);
    check({tag, ".drained"}, 64'(fifo_q.size() + pend_q.size()), 64'd0);
  endtask

  task automatic pop_expect(input string tag, input bit exp);
    bit acc;
    check(tag, result, 64'(exp));
    do_cycle(tag, 1'b0, 8'h46, 64'd0, 64'd0, 1'b1, acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    int          idx;
    int          dut_pops;
    logic [7:0]  bp_op [6];
    logic [63:0] bp_a  [6];
    logic [63:0] bp_b  [6];
    bit          bp_exp[6];
    logic [7:0]  op;
    logic [63:0] a, b;

    n_checks = 0; n_errors = 0; cyc = 0; m_trap = 1'b0;
    in_valid = 1'b0; opcode = 8'h00; lhs = '0; rhs = '0; result_pop = 1'b0; reset = 1'b0;
    #1;
    apply_reset("por");

    // Basic eq and latency
    do_cycle("eq5", 1'b1, 8'h46, 64'd5, 64'd5, 1'b0, acc);
    check("eq5.accepted", 64'(acc), 64'd1);
    do_cycle("eq5_n1", 1'b0, 8'h46, 64'd0, 64'd0, 1'b0, acc);
    check("eq5.empty_n1", 64'(result_empty), 64'd1);
    do_cycle("eq5_n2", 1'b0, 8'h46, 64'd0, 64'd0, 1'b0, acc);
    check("eq5.empty_n2", 64'(result_empty), 64'd0);
    pop_expect("eq5.value", 1'b1);
    check("eq5.after_pop_empty", 64'(result_empty), 64'd1);
    check("eq5.after_pop_result", result, 64'd0);

    // Signedness back to back
    do_cycle("sgn0", 1'b1, 8'h48, 64'hFFFF_FFFF, 64'd1, 1'b0, acc);
    do_cycle("sgn1", 1'b1, 8'h49, 64'hFFFF_FFFF, 64'd1, 1'b0, acc);
    do_cycle("sgn2", 1'b1, 8'h53, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, acc);
    idle("sgn_wait", 2, 1'b0);
    pop_expect("sgn.lt_s32", 1'b1);
    pop_expect("sgn.lt_u32", 1'b0);
    pop_expect("sgn.lt_s64", 1'b0);

    // Masking and eqz
    do_cycle("msk0", 1'b1, 8'h46, 64'h1_0000_0007, 64'h7, 1'b0, acc);
    do_cycle("msk1", 1'b1, 8'h45, 64'hABCD_0000_0000, 64'd0, 1'b0, acc);
    do_cycle("msk2", 1'b1, 8'h50, 64'hABCD_0000_0000, 64'd0, 1'b0, acc);
    idle("msk_wait", 2, 1'b0);
    pop_expect("msk.eq32", 1'b1);
    pop_expect("msk.eqz32", 1'b1);
    pop_expect("msk.eqz64", 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      op = 8'($urandom_range(32'h45, 32'h5A));
      a  = rnd_val();
      case ($urandom_range(0, 2))
        0:       b = a;
        1:       b = {~a[63:32], a[31:0]};
        default: b = rnd_val();
      endcase
      do_cycle("rnd", $urandom_range(0, 3) != 0, op, a, b, (i % 64 < 40) ? ($urandom_range(0, 2) != 0) : 1'b0, acc);
    end
    drain("rnd_drain");

    // Backpressure
    bp_op[0] = 8'h46; bp_a[0] = 64'd1; bp_b[0] = 64'd1; bp_exp[0] = 1'b1;
    bp_op[1] = 8'h46; bp_a[1] = 64'd1; bp_b[1] = 64'd2; bp_exp[1] = 1'b0;
    bp_op[2] = 8'h49; bp_a[2] = 64'd1; bp_b[2] = 64'd2; bp_exp[2] = 1'b1;
    bp_op[3] = 8'h4B; bp_a[3] = 64'd1; bp_b[3] = 64'd2; bp_exp[3] = 1'b0;
    bp_op[4] = 8'h4F; bp_a[4] = 64'd2; bp_b[4] = 64'd2; bp_exp[4] = 1'b1;
    bp_op[5] = 8'h52; bp_a[5] = 64'd3; bp_b[5] = 64'd3; bp_exp[5] = 1'b0;
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      do_cycle("bp_fill", idx < 6, bp_op[idx < 6 ? idx : 5], bp_a[idx < 6 ? idx : 5], bp_b[idx < 6 ? idx : 5], 1'b0, acc);
      if (acc) idx++;
    end
    check("bp.accepts_before_pop", 64'(idx), 64'd4);
    check("bp.in_ready_low_when_full", 64'(in_ready), 64'd0);
    dut_pops = 0;
    for (int i = 0; i < 30 && dut_pops < 6; i++) begin
      in_valid = 1'b0; result_pop = 1'b1;
      #1;
      if (!result_empty) begin
        check("bp.order", result, 64'(bp_exp[dut_pops]));
        dut_pops++;
      end
      do_cycle("bp_drain", idx < 6, bp_op[idx < 6 ? idx : 5], bp_a[idx < 6 ? idx : 5], bp_b[idx < 6 ? idx : 5], 1'b1, acc);
      if (acc) idx++;
    end
    check("bp.total_accepted", 64'(idx), 64'd6);
    check("bp.total_results", 64'(dut_pops), 64'd6);
    idle("bp_tail", 3, 1'b1);
    check("bp.no_duplicate", 64'(result_empty), 64'd1);

    // Reset mid-flight
    drain("mf_pre");
    do_cycle("mf0", 1'b1, 8'h46, 64'd4, 64'd4, 1'b0, acc);
    do_cycle("mf1", 1'b1, 8'h47, 64'd4, 64'd5, 1'b0, acc);
    apply_reset("mf");
    idle("mf_after", 6, 1'b0);
    check("mf.no_stale", 64'(result_empty), 64'd1);

    // Trap
    do_cycle("trap_eq", 1'b1, 8'h46, 64'd9, 64'd9, 1'b0, acc);
    do_cycle("trap_bad", 1'b1, 8'h60, 64'd0, 64'd0, 1'b0, acc);
    check("trap.code", 64'(trap), 64'd2);
    for (int i = 0; i < 4; i++) do_cycle("trap_hold", 1'b1, 8'h46, 64'd1, 64'd1, 1'b0, acc);
    check("trap.in_ready_low", 64'(in_ready), 64'd0);
    check("trap.eq_result", result, 64'd1);
    pop_expect("trap.eq_pop", 1'b1);
    check("trap.only_one_result", 64'(result_empty), 64'd1);
    apply_reset("trap_rst");
    check("trap.cleared", 64'(trap), 64'd0);
    idle("post", 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
